// File: rtl/mem_pkg.sv
// mem_pkg: state, write-back select and access width encodings shared by the memory stage
package mem_pkg;

   typedef enum logic [1:0] {IDLE, REQ, DONE} mem_state_t;

   localparam logic [1:0] WB_ALU = 2'b00;
   localparam logic [1:0] WB_MEM = 2'b01;
   localparam logic [1:0] WB_PC  = 2'b10;

   localparam logic [1:0] W_BYTE = 2'b00;
   localparam logic [1:0] W_HALF = 2'b01;
   localparam logic [1:0] W_WORD = 2'b10;

endpackage

// File: rtl/mem_access_stage_if.sv
// mem_access_stage_if: single-port data-memory bus with a req/ack handshake
interface mem_access_stage_if #(
   parameter int ADDR_W = 32
);
   logic              req;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [3:0]        be;
   logic [31:0]       wdata;
   logic [31:0]       rdata;
   logic              ack;

   modport master (
      output req, we, addr, be, wdata,
      input  rdata, ack
   );

   modport slave (
      input  req, we, addr, be, wdata,
      output rdata, ack
   );
endinterface

// File: rtl/load_store_align.sv
// load_store_align: store lane steering and load extraction with sign/zero extension
module load_store_align
   import mem_pkg::*;
(
   input  logic [1:0]  addr_lo,
   input  logic [1:0]  width,
   input  logic        is_unsigned,
   input  logic        is_store,
   input  logic [31:0] st_data,
   input  logic [31:0] rd_data,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   output logic [31:0] ld_data
);
   logic [31:0] shifted;

   always_comb begin
      shifted = rd_data >> {addr_lo, 3'b000};
      be      = !is_store ? 4'hf :
                width == W_BYTE ? 4'b0001 << addr_lo :
                width == W_HALF ? 4'b0011 << addr_lo : 4'hf;
      wdata   = width == W_BYTE ? {4{st_data[7:0]}} :
                width == W_HALF ? {2{st_data[15:0]}} : st_data;
      ld_data = width == W_BYTE ? {{24{shifted[7] & ~is_unsigned}}, shifted[7:0]} :
                width == W_HALF ? {{16{shifted[15] & ~is_unsigned}}, shifted[15:0]} : shifted;
   end
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM stage of the 5-stage RISC-V core; drives the data bus,
// stalls execute during an access and registers the MEM/WB pipeline outputs
module mem_access_stage
   import mem_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int ADDR_W         = 32
)(
   input  logic                clk,
   input  logic                rst,
   input  logic [31:0]         next_pc_mem,
   input  logic [31:0]         alu_result_mem,
   input  logic [31:0]         write_data_mem,
   input  logic [1:0]          wb_sel_mem,
   input  logic [1:0]          read_width_mem,
   input  logic                read_unsigned_mem,
   input  logic                rd_en_mem,
   input  logic                mem_wrt_en_mem,
   input  logic                reg_wrt_en_mem,
   input  logic [4:0]          wrt_dst_mem,
   mem_access_stage_if.master  dmem,
   output logic                stall_mem,
   output logic [31:0]         wbdata_wb,
   output logic [4:0]          wrt_dst_wb,
   output logic                reg_wrt_en_wb,
   output logic                misalign_err,
   output logic                bus_err
);
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   mem_state_t    state;
   logic [CW-1:0] cnt;
   logic          abort;
   logic [31:0]   rdata_q;
   logic [31:0]   ld_data;
   logic [31:0]   st_wdata;
   logic [31:0]   wb_val;
   logic [3:0]    st_be;
   logic          access;
   logic          misaligned;

   load_store_align u_align (
      .addr_lo     (alu_result_mem[1:0]),
      .width       (read_width_mem),
      .is_unsigned (read_unsigned_mem),
      .is_store    (mem_wrt_en_mem),
      .st_data     (write_data_mem),
      .rd_data     (rdata_q),
      .be          (st_be),
      .wdata       (st_wdata),
      .ld_data     (ld_data)
   );

   // Bus fields are held at zero outside REQ so the idle bus is quiet.
   always_comb begin
      access     = rd_en_mem | mem_wrt_en_mem;
      misaligned = (read_width_mem == W_HALF && alu_result_mem[0]) ||
                   (read_width_mem[1] && alu_result_mem[1:0] != 2'b00);
      wb_val     = wb_sel_mem == WB_MEM ? ld_data :
                   wb_sel_mem == WB_PC ? next_pc_mem : alu_result_mem;
      stall_mem  = state == REQ || (state == IDLE && access && !misaligned);
      dmem.req   = state == REQ;
      dmem.we    = state == REQ && mem_wrt_en_mem;
      dmem.addr  = state == REQ ? ADDR_W'({alu_result_mem[31:2], 2'b00}) : '0;
      dmem.be    = state == REQ ? st_be : 4'h0;
      dmem.wdata = state == REQ && mem_wrt_en_mem ? st_wdata : '0;
   end

   // While an access is outstanding the WB side sees a bubble, so a stalled
   // instruction never writes the register file twice.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         cnt           <= '0;
         abort         <= 1'b0;
         rdata_q       <= '0;
         wbdata_wb     <= '0;
         wrt_dst_wb    <= '0;
         reg_wrt_en_wb <= 1'b0;
         misalign_err  <= 1'b0;
         bus_err       <= 1'b0;
      end else begin
         misalign_err <= 1'b0;
         bus_err      <= 1'b0;
         if (state == IDLE) begin
            if (stall_mem) begin
               state         <= REQ;
               cnt           <= '0;
               abort         <= 1'b0;
               reg_wrt_en_wb <= 1'b0;
            end else begin
               wbdata_wb     <= wb_val;
               wrt_dst_wb    <= wrt_dst_mem;
               reg_wrt_en_wb <= reg_wrt_en_mem & ~access;
               misalign_err  <= access;
            end
         end else if (state == REQ) begin
            if (dmem.ack) begin
               rdata_q <= dmem.rdata;
               state   <= DONE;
            end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
               abort   <= 1'b1;
               bus_err <= 1'b1;
               state   <= DONE;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end else begin
            wbdata_wb     <= wb_val;
            wrt_dst_wb    <= wrt_dst_mem;
            reg_wrt_en_wb <= reg_wrt_en_mem & ~abort;
            state         <= IDLE;
         end
      end
   end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: vector table driven through a scoreboard plus reset and stray-ack sequences
module tb_mem_access_stage;
   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] next_pc_mem, alu_result_mem, write_data_mem;
   logic [1:0]  wb_sel_mem, read_width_mem;
   logic        read_unsigned_mem, rd_en_mem, mem_wrt_en_mem, reg_wrt_en_mem;
   logic [4:0]  wrt_dst_mem;
   logic        stall_mem;
   logic [31:0] wbdata_wb;
   logic [4:0]  wrt_dst_wb;
   logic        reg_wrt_en_wb, misalign_err, bus_err;
   int          checks = 0;
   int          errors = 0;

   mem_access_stage_if #(.ADDR_W(32)) dmem ();

   mem_access_stage #(.TIMEOUT_CYCLES(4), .ADDR_W(32)) dut (
      .clk               (clk),
      .rst               (rst),
      .next_pc_mem       (next_pc_mem),
      .alu_result_mem    (alu_result_mem),
      .write_data_mem    (write_data_mem),
      .wb_sel_mem        (wb_sel_mem),
      .read_width_mem    (read_width_mem),
      .read_unsigned_mem (read_unsigned_mem),
      .rd_en_mem         (rd_en_mem),
      .mem_wrt_en_mem    (mem_wrt_en_mem),
      .reg_wrt_en_mem    (reg_wrt_en_mem),
      .wrt_dst_mem       (wrt_dst_mem),
      .dmem              (dmem.master),
      .stall_mem         (stall_mem),
      .wbdata_wb         (wbdata_wb),
      .wrt_dst_wb        (wrt_dst_wb),
      .reg_wrt_en_wb     (reg_wrt_en_wb),
      .misalign_err      (misalign_err),
      .bus_err           (bus_err)
   );

   always #5 clk = ~clk;

   // waits: REQ cycles before ack (-1 = never); e_*: expected results
   typedef struct {
      logic [31:0] alu, wd, pc, rdata;
      logic [1:0]  sel, width;
      logic        uns, rd, wr, ren;
      logic [4:0]  dst;
      int          waits;
      logic [31:0] e_wb;
      logic        e_en, e_mis;
      int          e_stall, e_req, e_berr;
      logic [3:0]  e_be;
      logic        e_we;
      logic [31:0] e_wdata;
   } vec_t;

   vec_t vecs[16];
   vec_t sb[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      alu_result_mem    = v.alu;
      write_data_mem    = v.wd;
      next_pc_mem       = v.pc;
      wb_sel_mem        = v.sel;
      read_width_mem    = v.width;
      read_unsigned_mem = v.uns;
      rd_en_mem         = v.rd;
      mem_wrt_en_mem    = v.wr;
      reg_wrt_en_mem    = v.ren;
      wrt_dst_mem       = v.dst;
   endtask

   task automatic clear_in();
      alu_result_mem    = '0;
      write_data_mem    = '0;
      next_pc_mem       = '0;
      wb_sel_mem        = '0;
      read_width_mem    = '0;
      read_unsigned_mem = 1'b0;
      rd_en_mem         = 1'b0;
      mem_wrt_en_mem    = 1'b0;
      reg_wrt_en_mem    = 1'b0;
      wrt_dst_mem       = '0;
   endtask

   // Holds one instruction in EX/MEM until the stage releases it, acting as the memory.
   task automatic run_vec(input int idx, input vec_t v);
      vec_t e;
      int   stalls, reqs, berr;
      bit   done;
      stalls = 0;
      reqs   = 0;
      berr   = 0;
      done   = 1'b0;
      drive(v);
      sb.push_back(v);
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clk);
         if (dmem.req) begin
            if (reqs == 0) begin
               chk($sformatf("v%0d addr", idx), dmem.addr, sb[0].alu & 32'hffff_fffc);
               chk($sformatf("v%0d we", idx), dmem.we, sb[0].e_we);
               chk($sformatf("v%0d be", idx), dmem.be, sb[0].e_be);
               if (sb[0].e_we) chk($sformatf("v%0d wdata", idx), dmem.wdata, sb[0].e_wdata);
            end
            if (reqs == v.waits) begin
               dmem.ack   = 1'b1;
               dmem.rdata = v.rdata;
            end
            reqs++;
         end
         stalls += int'(stall_mem);
         berr   += int'(bus_err);
         done    = !stall_mem;
         @(posedge clk);
         #1;
         dmem.ack   = 1'b0;
         dmem.rdata = 32'h5a5a_5a5a;
      end
      chk($sformatf("v%0d completed", idx), done, 1'b1);
      e = sb.pop_front();
      chk($sformatf("v%0d stall_cycles", idx), stalls, e.e_stall);
      chk($sformatf("v%0d req_cycles", idx), reqs, e.e_req);
      chk($sformatf("v%0d bus_err_pulses", idx), berr, e.e_berr);
      chk($sformatf("v%0d reg_wrt_en_wb", idx), reg_wrt_en_wb, e.e_en);
      chk($sformatf("v%0d misalign_err", idx), misalign_err, e.e_mis);
      if (e.e_en) begin
         chk($sformatf("v%0d wbdata_wb", idx), wbdata_wb, e.e_wb);
         chk($sformatf("v%0d wrt_dst_wb", idx), wrt_dst_wb, e.dst);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t r;
      bit   got;
      //           alu           wd            pc            rdata         sel    wid    u  rd wr en dst     waits e_wb          en mis st rq be  e_be   we e_wdata
      vecs[0]  = '{32'h1234,     32'h0,        32'h0,        32'h0,        2'd0, 2'd2, 0, 0, 0, 1, 5'd5,  -1, 32'h0000_1234, 1, 0, 0, 0, 0, 4'h0, 0, 32'h0};
      vecs[1]  = '{32'h103,      32'h0,        32'h0,        32'h80FF_0000,2'd1, 2'd0, 0, 1, 0, 1, 5'd7,   2, 32'hFFFF_FF80, 1, 0, 4, 3, 0, 4'hF, 0, 32'h0};
      vecs[2]  = '{32'h202,      32'hABCD_1234,32'h0,        32'h0,        2'd0, 2'd1, 0, 0, 1, 0, 5'd0,   0, 32'h0,         0, 0, 2, 1, 0, 4'hC, 1, 32'h1234_1234};
      vecs[3]  = '{32'h301,      32'h0,        32'h0,        32'h0,        2'd1, 2'd2, 0, 1, 0, 1, 5'd9,  -1, 32'h0,         0, 1, 0, 0, 0, 4'h0, 0, 32'h0};
      vecs[4]  = '{32'h102,      32'h0,        32'h0,        32'h0,        2'd1, 2'd1, 1, 1, 0, 1, 5'd3,  -1, 32'h0,         0, 0, 5, 4, 1, 4'hF, 0, 32'h0};
      vecs[5]  = '{32'h101,      32'h0,        32'h0,        32'h1234_AB00,2'd1, 2'd0, 1, 1, 0, 1, 5'd10,  1, 32'h0000_00AB, 1, 0, 3, 2, 0, 4'hF, 0, 32'h0};
      vecs[6]  = '{32'h102,      32'h0,        32'h0,        32'h8001_0000,2'd1, 2'd1, 0, 1, 0, 1, 5'd11,  0, 32'hFFFF_8001, 1, 0, 2, 1, 0, 4'hF, 0, 32'h0};
      vecs[7]  = '{32'h104,      32'h0,        32'h0,        32'hDEAD_BEEF,2'd1, 2'd2, 0, 1, 0, 1, 5'd12,  0, 32'hDEAD_BEEF, 1, 0, 2, 1, 0, 4'hF, 0, 32'h0};
      vecs[8]  = '{32'h305,      32'h0000_00A5,32'h0,        32'h0,        2'd0, 2'd0, 0, 0, 1, 0, 5'd0,   0, 32'h0,         0, 0, 2, 1, 0, 4'h2, 1, 32'hA5A5_A5A5};
      vecs[9]  = '{32'h400,      32'h1122_3344,32'h0,        32'h0,        2'd0, 2'd2, 0, 0, 1, 0, 5'd0,   0, 32'h0,         0, 0, 2, 1, 0, 4'hF, 1, 32'h1122_3344};
      vecs[10] = '{32'h5555,     32'h0,        32'h2004,     32'h0,        2'd2, 2'd2, 0, 0, 0, 1, 5'd1,  -1, 32'h0000_2004, 1, 0, 0, 0, 0, 4'h0, 0, 32'h0};
      vecs[11] = '{32'h6666,     32'h0,        32'h2004,     32'h0,        2'd3, 2'd2, 0, 0, 0, 1, 5'd31, -1, 32'h0000_6666, 1, 0, 0, 0, 0, 4'h0, 0, 32'h0};
      vecs[12] = '{32'h203,      32'h0,        32'h0,        32'h0,        2'd0, 2'd1, 0, 0, 1, 0, 5'd0,  -1, 32'h0,         0, 1, 0, 0, 0, 4'h0, 0, 32'h0};
      vecs[13] = '{32'h002,      32'h0000_0077,32'h0,        32'h0,        2'd0, 2'd0, 0, 1, 1, 1, 5'd4,   0, 32'h0000_0002, 1, 0, 2, 1, 0, 4'h4, 1, 32'h7777_7777};
      vecs[14] = '{32'h500,      32'h0,        32'h0,        32'hCAFE_F00D,2'd1, 2'd3, 0, 1, 0, 1, 5'd13,  1, 32'hCAFE_F00D, 1, 0, 3, 2, 0, 4'hF, 0, 32'h0};
      vecs[15] = '{32'h100,      32'h0,        32'h0,        32'h0000_007F,2'd1, 2'd0, 0, 1, 0, 1, 5'd14,  0, 32'h0000_007F, 1, 0, 2, 1, 0, 4'hF, 0, 32'h0};

      rst        = 1'b1;
      dmem.ack   = 1'b0;
      dmem.rdata = '0;
      clear_in();
      repeat (2) @(posedge clk);
      #1;
      chk("reset req", dmem.req, 1'b0);
      chk("reset stall", stall_mem, 1'b0);
      chk("reset wbdata", wbdata_wb, 32'h0);
      chk("reset dst", wrt_dst_wb, 5'd0);
      chk("reset en", reg_wrt_en_wb, 1'b0);
      chk("reset misalign", misalign_err, 1'b0);
      chk("reset bus_err", bus_err, 1'b0);
      rst = 1'b0;

      for (int i = 0; i < 16; i++) run_vec(i, vecs[i]);

      // Reset arriving while a load is waiting on the bus.
      r     = vecs[7];
      r.alu = 32'h600;
      drive(r);
      got = 1'b0;
      for (int c = 0; c < 10 && !got; c++) begin
         @(negedge clk);
         got = dmem.req;
      end
      chk("rst_mid_req reached REQ", got, 1'b1);
      rst = 1'b1;
      clear_in();
      @(posedge clk);
      #1;
      chk("rst_mid_req req", dmem.req, 1'b0);
      chk("rst_mid_req stall", stall_mem, 1'b0);
      chk("rst_mid_req wbdata", wbdata_wb, 32'h0);
      chk("rst_mid_req dst", wrt_dst_wb, 5'd0);
      chk("rst_mid_req en", reg_wrt_en_wb, 1'b0);
      chk("rst_mid_req bus_err", bus_err, 1'b0);
      rst = 1'b0;

      // A stray ack while idle must not start or disturb anything.
      r     = vecs[0];
      r.alu = 32'h77;
      r.dst = 5'd2;
      drive(r);
      dmem.ack   = 1'b1;
      dmem.rdata = 32'hDEAD_BEEF;
      @(posedge clk);
      #1;
      chk("stray_ack wbdata", wbdata_wb, 32'h77);
      chk("stray_ack en", reg_wrt_en_wb, 1'b1);
      chk("stray_ack dst", wrt_dst_wb, 5'd2);
      @(negedge clk);
      chk("stray_ack req", dmem.req, 1'b0);
      chk("stray_ack stall", stall_mem, 1'b0);
      dmem.ack = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory stage of the 5-stage RISC-V core; consumes the EX/MEM pipeline register outputs of the execute stage.
- Drives a single-port data-memory bus with a req/ack handshake.
- Generates stall_mem back to the execute stage.
- Performs sub-word store lane steering and load extraction with sign/zero extension.
- Selects write-back data and registers the MEM/WB pipeline outputs.

Parameters:
- TIMEOUT_CYCLES, 255: max REQ cycles without dmem_ack before the access is aborted with bus_err.
- ADDR_W, 32: data-memory address width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- next_pc_mem  in  32  PC+4 of the instruction in MEM
- alu_result_mem  in  32  effective address or ALU result
- write_data_mem  in  32  store data, unshifted
- wb_sel_mem  in  2  00 ALU, 01 load data, 10 next_pc, 11 ALU
- read_width_mem  in  2  00 byte, 01 half, 10 word, 11 treated as word
- read_unsigned_mem  in  1  zero-extend loads when 1
- rd_en_mem  in  1  load instruction
- mem_wrt_en_mem  in  1  store instruction; also sets store width via read_width_mem
- reg_wrt_en_mem  in  1  register write-back enable
- wrt_dst_mem  in  5  destination register
- dmem_req  out  1  request valid; held until ack
- dmem_we  out  1  1 write, 0 read
- dmem_addr  out  ADDR_W  word-aligned address (alu_result_mem with [1:0] = 0)
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-steered store data
- dmem_rdata  in  32  read data, valid with ack
- dmem_ack  in  1  one-cycle completion
- stall_mem  out  1  freeze EX/MEM and earlier stages
- wbdata_wb  out  32  registered write-back data
- wrt_dst_wb  out  5  registered destination
- reg_wrt_en_wb  out  1  registered write enable
- misalign_err  out  1  one-cycle pulse on misaligned access
- bus_err  out  1  one-cycle pulse on timeout

Behaviour:
- Reset: state IDLE; timeout counter 0; all outputs 0, including dmem_req, stall_mem, wbdata_wb, wrt_dst_wb, reg_wrt_en_wb, misalign_err and bus_err. Reset mid-REQ drops dmem_req in the next cycle. No partial write-back occurs.
- Access is defined as rd_en_mem | mem_wrt_en_mem. If both are set, the access is a store.
- Misaligned is defined as: half with addr[0] = 1, or word with addr[1:0] != 0.
- IDLE, no access: stall_mem = 0. At the clock edge, MEM/WB latches the wb_sel result; reg_wrt_en_wb = reg_wrt_en_mem. Latency is 1 cycle.
- IDLE, misaligned access: no dmem_req and no stall. Next cycle misalign_err = 1 and reg_wrt_en_wb = 0. State stays IDLE.
- IDLE, aligned access: stall_mem = 1 (combinational); next state REQ; counter cleared.
- REQ:
  - dmem_req = 1; stall_mem = 1; addr, we, be and wdata are stable, sourced from the stalled EX/MEM register.
  - On dmem_ack: capture dmem_rdata into rdata_q; next state DONE.
  - Otherwise the counter increments. When counter == TIMEOUT_CYCLES - 1 without ack, set bus_err next cycle and go to DONE with abort flag set.
- DONE:
  - stall_mem = 0 and dmem_req = 0.
  - MEM/WB latches: wbdata from rdata_q (load) or the wb_sel source.
  - reg_wrt_en_wb = reg_wrt_en_mem & ~abort.
  - Next state IDLE.
  - Minimum aligned access cost is 3 cycles (IDLE, REQ, DONE), plus 1 per wait cycle.
- Store lanes:
  - byte: be = 0001 << addr[1:0]; wdata = data[7:0] replicated x4.
  - half: be = 0011 << addr[1:0]; wdata = data[15:0] replicated x2.
  - word: be = 1111.
- Loads: shift rdata_q right by 8*addr[1:0], then sign- or zero-extend from bit 7 (byte), bit 15 (half), or none (word). be = 1111 for reads.
- dmem_ack outside REQ is ignored.
- The execute stage sees stall_mem combinationally in every IDLE-with-aligned-access cycle and every REQ cycle.

Decomposition:
- Shared package mem_pkg holds:
  - enum mem_state_t {IDLE, REQ, DONE}
  - localparams for wb_sel encodings (WB_ALU, WB_MEM, WB_PC) and width encodings (W_BYTE, W_HALF, W_WORD)
- One combinational sub-module, load_store_align: produces be, wdata, and the extended load data from addr[1:0], width and unsigned.
- FSM, timeout counter and MEM/WB registers stay in the top module.

Test Plan:
- ALU op, wb_sel = 00, alu_result_mem = 0x1234, reg_wrt_en = 1, dst = 5 -> next cycle wbdata_wb = 0x1234, wrt_dst_wb = 5, stall_mem never set.
- lb, addr 0x103, signed, ack after 2 waits, rdata = 0x80FF_0000 -> stall for 4 cycles; wbdata_wb = 0xFFFF_FF80; dmem_addr = 0x100.
- sh, addr 0x202, data 0xABCD_1234, immediate ack -> dmem_be = 1100, dmem_wdata = 0x1234_1234, dmem_we = 1; reg_wrt_en_wb = 0.
- lw, addr 0x301 -> no dmem_req, misalign_err pulses 1 cycle, reg_wrt_en_wb = 0, no stall.
- lhu, no ack with TIMEOUT_CYCLES = 4 -> dmem_req high 4 cycles, then bus_err pulse, reg_wrt_en_wb = 0, back to IDLE.
- rst asserted during REQ -> next cycle dmem_req = 0, stall_mem = 0, state IDLE, all MEM/WB outputs 0.
